// File: rtl/retire_trace_pkg.sv
// Shared types for the retirement trace buffer: trace entry payload, FSM states
// and the drop-counter ceiling.
package retire_trace_pkg;

  typedef struct packed {
    logic [31:0] seq;
    logic [31:0] pc;
    logic [31:0] insn;
    logic        we;
    logic [4:0]  dst;
    logic [31:0] value;
  } retire_entry_t;

  typedef enum logic {RUN, DROP} trace_state_e;

  localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == DROP_CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/retire_trace_buffer_if.sv
// Write-back capture and trace-consumer signals of the retirement trace buffer.
// The master side drives retirements and ready; the slave side is the buffer.
interface retire_trace_buffer_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          wb_valid_i;
  logic [31:0]   wb_pc_i;
  logic [31:0]   wb_insn_i;
  logic          wb_we_i;
  logic [4:0]    wb_dst_i;
  logic [31:0]   wb_r_i;

  logic          trace_valid_o;
  logic          trace_ready_i;
  logic [31:0]   trace_seq_o;
  logic [31:0]   trace_pc_o;
  logic [31:0]   trace_insn_o;
  logic [31:0]   trace_value_o;
  logic          trace_we_o;
  logic [4:0]    trace_dst_o;

  logic [CW-1:0] count_o;
  logic          overflow_o;
  logic [15:0]   drop_cnt_o;

  modport master (
    output wb_valid_i, wb_pc_i, wb_insn_i, wb_we_i, wb_dst_i, wb_r_i, trace_ready_i,
    input  trace_valid_o, trace_seq_o, trace_pc_o, trace_insn_o, trace_value_o,
           trace_we_o, trace_dst_o, count_o, overflow_o, drop_cnt_o
  );

  modport slave (
    input  wb_valid_i, wb_pc_i, wb_insn_i, wb_we_i, wb_dst_i, wb_r_i, trace_ready_i,
    output trace_valid_o, trace_seq_o, trace_pc_o, trace_insn_o, trace_value_o,
           trace_we_o, trace_dst_o, count_o, overflow_o, drop_cnt_o
  );

endinterface

// File: rtl/retire_fifo.sv
// Circular FIFO of trace entries; the owner guarantees no push when full
// (unless popping) and no pop when empty.
module retire_fifo
  import retire_trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  retire_entry_t              push_data,
  input  logic                       pop,
  output retire_entry_t              pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  retire_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage is deliberately not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);

endmodule

// File: rtl/retire_trace_buffer.sv
// Captures retired instructions into a trace FIFO, dropping and counting them while full.
// Define RETIRE_TRACE_X0_FILTER_EN to record writes to x0 as we=0, value=0.
module retire_trace_buffer
  import retire_trace_pkg::*;
#(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] SEQ_INIT = 32'h0
) (
  input logic                  clk,
  input logic                  rst_n,
  retire_trace_buffer_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("retire_trace_buffer: DEPTH must be a power of two in 2..64");
  end

  trace_state_e  state;
  logic [31:0]   seq;
  logic          overflow;
  logic [15:0]   drop_cnt;
  logic          push;
  logic          pop;
  logic          drop;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  retire_entry_t wr_entry;
  retire_entry_t head;

  assign pop  = !empty && bus.trace_ready_i;
  assign push = bus.wb_valid_i && (state == RUN) && (!full || pop);
  assign drop = bus.wb_valid_i && !push;

  always_comb begin
    wr_entry      = '0;
    wr_entry.seq  = seq;
    wr_entry.pc   = bus.wb_pc_i;
    wr_entry.insn = bus.wb_insn_i;
    wr_entry.dst  = bus.wb_dst_i;
`ifdef RETIRE_TRACE_X0_FILTER_EN
    wr_entry.we    = bus.wb_we_i && (bus.wb_dst_i != 5'd0);
    wr_entry.value = (bus.wb_dst_i == 5'd0) ? 32'h0 : bus.wb_r_i;
`else
    wr_entry.we    = bus.wb_we_i;
    wr_entry.value = bus.wb_r_i;
`endif
  end

  retire_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (wr_entry),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // Sequence numbers advance on every retirement so the consumer can spot dropped ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      seq      <= SEQ_INIT;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (bus.wb_valid_i) begin
        seq <= seq + 32'd1;
      end
      if (drop) begin
        overflow <= 1'b1;
        drop_cnt <= sat_inc16(drop_cnt);
      end
      case (state)
        RUN: begin
          if (drop) begin
            state <= DROP;
          end
        end
        DROP: begin
          if (count == CW'(pop)) begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign bus.trace_valid_o = !empty;
  assign bus.trace_seq_o   = empty ? 32'h0 : head.seq;
  assign bus.trace_pc_o    = empty ? 32'h0 : head.pc;
  assign bus.trace_insn_o  = empty ? 32'h0 : head.insn;
  assign bus.trace_we_o    = empty ? 1'b0  : head.we;
  assign bus.trace_dst_o   = empty ? 5'd0  : head.dst;
  assign bus.trace_value_o = empty ? 32'h0 : head.value;
  assign bus.count_o       = count;
  assign bus.overflow_o    = overflow;
  assign bus.drop_cnt_o    = drop_cnt;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Randomised scoreboard bench for retire_trace_buffer: a queue-based model predicts
// stored entries and status; a negedge monitor checks every accepted trace entry.
module tb_retire_trace_buffer;
  import retire_trace_pkg::*;

  localparam int          DEPTH    = 8;
  localparam logic [31:0] SEQ_INIT = 32'hFFFF_FFFE;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  retire_entry_t exp_q[$];
  int            m_count;
  logic [31:0]   m_seq;
  bit            m_drop_mode;
  bit            m_ovf;
  bit            m_any_push;
  logic [15:0]   m_drop_cnt;
  int            rdy_pct[4] = '{90, 30, 0, 60};

  retire_trace_buffer_if #(.DEPTH(DEPTH)) bus ();

  retire_trace_buffer #(.DEPTH(DEPTH), .SEQ_INIT(SEQ_INIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkEntry(input string name, input retire_entry_t act, input retire_entry_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual seq=%h pc=%h insn=%h we=%b dst=%0d val=%h expected seq=%h pc=%h insn=%h we=%b dst=%0d val=%h",
               name, act.seq, act.pc, act.insn, act.we, act.dst, act.value,
               exp.seq, exp.pc, exp.insn, exp.we, exp.dst, exp.value);
    end
  endtask

  function automatic retire_entry_t sampleHead();
    retire_entry_t e;
    e.seq   = bus.trace_seq_o;
    e.pc    = bus.trace_pc_o;
    e.insn  = bus.trace_insn_o;
    e.we    = bus.trace_we_o;
    e.dst   = bus.trace_dst_o;
    e.value = bus.trace_value_o;
    return e;
  endfunction

  task automatic resetModel();
    exp_q.delete();
    m_count     = 0;
    m_seq       = SEQ_INIT;
    m_drop_mode = 0;
    m_ovf       = 0;
    m_any_push  = 0;
    m_drop_cnt  = 16'd0;
  endtask

  task automatic checkOutput();
    check("count", 32'(bus.count_o), m_count);
    check("trace_valid", 32'(bus.trace_valid_o), 32'(m_count != 0));
    check("overflow", 32'(bus.overflow_o), 32'(m_ovf));
    check("drop_cnt", 32'(bus.drop_cnt_o), 32'(m_drop_cnt));
    if (!m_any_push) begin
      check("fields_zero_after_reset",
            bus.trace_seq_o | bus.trace_pc_o | bus.trace_insn_o | bus.trace_value_o
            | {26'd0, bus.trace_we_o, bus.trace_dst_o}, 32'h0);
    end
  endtask

  // One clock cycle: check status of the previous edge, drive inputs, predict the next edge.
  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] insn,
                               input logic we, input logic [4:0] dst, input logic [31:0] r,
                               input logic rdy, input bit chk);
    bit            pop;
    bit            stored;
    retire_entry_t e;
    @(posedge clk);
    #1;
    if (chk) checkOutput();
    bus.wb_valid_i    = v;
    bus.wb_pc_i       = pc;
    bus.wb_insn_i     = insn;
    bus.wb_we_i       = we;
    bus.wb_dst_i      = dst;
    bus.wb_r_i        = r;
    bus.trace_ready_i = rdy;
    pop    = (m_count > 0) && rdy;
    stored = 0;
    if (v) begin
      stored = !m_drop_mode && (m_count < DEPTH || pop);
      if (stored) begin
        e.seq  = m_seq;
        e.pc   = pc;
        e.insn = insn;
        e.dst  = dst;
`ifdef RETIRE_TRACE_X0_FILTER_EN
        e.we    = (dst == 5'd0) ? 1'b0 : we;
        e.value = (dst == 5'd0) ? 32'h0 : r;
`else
        e.we    = we;
        e.value = r;
`endif
        exp_q.push_back(e);
        m_any_push = 1;
      end else begin
        m_ovf       = 1;
        m_drop_mode = 1;
        if (m_drop_cnt != 16'hFFFF) m_drop_cnt = m_drop_cnt + 16'd1;
      end
      m_seq = m_seq + 32'd1;
    end
    m_count = m_count - int'(pop) + int'(stored);
    if (m_drop_mode && m_count == 0) m_drop_mode = 0;
  endtask

  task automatic idle(input int n, input logic rdy);
    repeat (n) applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, rdy, 1'b1);
  endtask

  task automatic retireRandom(input int pct_valid, input int pct_ready, input bit chk);
    logic [4:0] dst;
    dst = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    applyStimulus(1'($urandom_range(0, 99) < pct_valid), $urandom, $urandom, 1'($urandom_range(0, 1)),
                  dst, $urandom, 1'($urandom_range(0, 99) < pct_ready), chk);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst_n             = 1'b0;
    bus.wb_valid_i    = 1'b0;
    bus.trace_ready_i = 1'b0;
    resetModel();
    #1;
    check("valid_async_reset", 32'(bus.trace_valid_o), 32'h0);
    check("count_async_reset", 32'(bus.count_o), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: every accepted head entry must match the oldest predicted entry, and
  // a stalled head must not change.
  initial begin : monitor
    retire_entry_t act;
    retire_entry_t hold_entry;
    bit            hold_pending;
    hold_pending = 0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.trace_valid_o) begin
        act = sampleHead();
        if (hold_pending) checkEntry("hold_stable", act, hold_entry);
        if (bus.trace_ready_i) begin
          hold_pending = 0;
          if (exp_q.size() == 0) begin
            check("unexpected_entry", act.seq, 32'h0);
          end else begin
            checkEntry("trace_entry", act, exp_q.pop_front());
          end
        end else begin
          hold_pending = 1;
          hold_entry   = act;
        end
      end else begin
        hold_pending = 0;
      end
    end
  end

  initial begin : stimulus
    bus.wb_valid_i    = 1'b0;
    bus.wb_pc_i       = 32'h0;
    bus.wb_insn_i     = 32'h0;
    bus.wb_we_i       = 1'b0;
    bus.wb_dst_i      = 5'd0;
    bus.wb_r_i        = 32'h0;
    bus.trace_ready_i = 1'b0;
    resetModel();
    doReset();

    $display("[TB] three back-to-back retirements, consumer ready");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 32'h200 + 32'(4 * i), 32'h13, 1'b1, 5'd1, 32'(i), 1'b1, 1'b1);
    idle(3, 1'b1);

    $display("[TB] overflow into drop mode, drain, resume");
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b1, 32'h300 + 32'(4 * i), $urandom, 1'b1, 5'd2, $urandom, 1'b0, 1'b1);
    idle(8, 1'b1);
    applyStimulus(1'b1, 32'h400, 32'h33, 1'b1, 5'd4, 32'h44, 1'b1, 1'b1);
    idle(3, 1'b1);

    $display("[TB] push and pop together while full");
    doReset();
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b1, 32'h500 + 32'(4 * i), $urandom, 1'b0, 5'd5, $urandom, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'hABC0, 32'h77, 1'b1, 5'd6, 32'h66, 1'b1, 1'b1);
    idle(2, 1'b0);
    idle(DEPTH + 2, 1'b1);

    $display("[TB] write to x0");
    applyStimulus(1'b1, 32'h600, 32'h00000013, 1'b1, 5'd0, 32'hDEADBEEF, 1'b1, 1'b1);
    idle(2, 1'b1);

    $display("[TB] reset with entries queued");
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 32'h700 + 32'(4 * i), $urandom, 1'b1, 5'd7, $urandom, 1'b0, 1'b1);
    doReset();
    applyStimulus(1'b1, 32'h800, 32'h88, 1'b1, 5'd8, 32'h99, 1'b1, 1'b1);
    idle(2, 1'b1);

    $display("[TB] randomised traffic");
    for (int phase = 0; phase < 8; phase++) begin
      for (int i = 0; i < 200; i++) retireRandom(65, rdy_pct[phase % 4], 1'b1);
    end
    idle(DEPTH + 2, 1'b1);

    $display("[TB] stalled head, then drop counter saturation");
    doReset();
    for (int i = 0; i < 70010; i++)
      applyStimulus(1'b1, $urandom, $urandom, 1'b1, 5'd3, $urandom, 1'b0,
                    (i < 16) || (i % 4096 == 0) || (i >= 70000));
    idle(DEPTH + 2, 1'b1);
    applyStimulus(1'b1, 32'h900, 32'h99, 1'b1, 5'd9, 32'h1234, 1'b1, 1'b1);
    idle(3, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
